// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for the
// byte-addressed data memory. One access at a time runs through the
// IDLE -> ACCESS -> DONE sequence. Memory-side fields come from registers that
// are latched when a request is granted.
//
// Handshake: a requester raises reqN with weN/typeN/addrN/wdataN and keeps
// them stable until ackN. ackN is a single-cycle pulse, and rdataN/errN are
// valid in that cycle. If req is still high after the ack cycle, it counts as
// a new request. ack0 and ack1 are never high together.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     we0,
    input  logic [1:0]               type0,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic [1:0]               type1,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     ack0,
    output logic [DATA_WIDTH-1:0]    rdata0,
    output logic                     err0,
    output logic                     ack1,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic                     err1,
    output logic                     mem_we,
    output logic [1:0]               mem_type,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_ILLEGAL = 2'b11;

    state_t state_q, state_d;

    logic                     l_we;
    logic [1:0]               l_type;
    logic [ADDRESS_WIDTH-1:0] l_addr;
    logic [DATA_WIDTH-1:0]    l_wdata;
    logic                     l_port;
    logic                     last_grant;
    logic [DATA_WIDTH-1:0]    rdata0_q;
    logic [DATA_WIDTH-1:0]    rdata1_q;

    logic any_req;
    logic pick1;
    logic l_illegal;

    // On a tie, port 1 wins only when port 0 was the last port granted.
    assign any_req   = req0 | req1;
    assign pick1     = req1 & (~req0 | ~last_grant);
    assign l_illegal = (l_type == TYPE_ILLEGAL);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: a granted access always takes exactly three cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state. An illegal size never reaches the write enable.
    always_comb begin
        mem_we = 1'b0;
        ack0   = 1'b0;
        ack1   = 1'b0;
        err0   = 1'b0;
        err1   = 1'b0;
        case (state_q)
            ACCESS: mem_we = l_we & ~l_illegal;
            DONE: begin
                ack0 = ~l_port;
                ack1 = l_port;
                err0 = ~l_port & l_illegal;
                err1 = l_port & l_illegal;
            end
            default: ;
        endcase
    end

    // Latch the winning request's fields in IDLE. Later changes on the ports
    // cannot disturb the in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_we    <= 1'b0;
            l_type  <= 2'b00;
            l_addr  <= '0;
            l_wdata <= '0;
            l_port  <= 1'b0;
        end else if (state_q == IDLE && any_req) begin
            l_port  <= pick1;
            l_we    <= pick1 ? we1    : we0;
            l_type  <= pick1 ? type1  : type0;
            l_addr  <= pick1 ? addr1  : addr0;
            l_wdata <= pick1 ? wdata1 : wdata0;
        end
    end

    // Capture read data and record the grant at the end of ACCESS.
    // Writes and illegal accesses return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else if (state_q == ACCESS) begin
            last_grant <= l_port;
            if (l_port) rdata1_q <= (l_we | l_illegal) ? '0 : mem_rdata;
            else        rdata0_q <= (l_we | l_illegal) ? '0 : mem_rdata;
        end
    end

    assign mem_type  = l_type;
    assign mem_addr  = l_addr;
    assign mem_wdata = l_wdata;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory model, a table of single-port
// transactions, and hand-written contention, reset and back-to-back sequences.
module tb_dmem_arbiter;

    localparam int AW = 17;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_init = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [1:0]    type0 = 2'b00, type1 = 2'b00;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err0, err1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [1:0]    mem_type, dbg_state;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int overlap_cnt = 0;
    logic [DW-1:0] exp_r0 = '0;
    logic [DW-1:0] exp_r1 = '0;

    logic [7:0] mem [0:(1<<AW)-1];

    dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .type0(type0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .type1(type1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory model: little-endian bytes, sized and sign-extended reads.
    // Type 11 reads return the full word, so zeroing must come from the DUT.
    always_comb begin
        case (mem_type)
            2'b01:   mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
            2'b10:   mem_rdata = {{16{mem[mem_addr + 17'd1][7]}}, mem[mem_addr + 17'd1], mem[mem_addr]};
            default: mem_rdata = {mem[mem_addr + 17'd3], mem[mem_addr + 17'd2],
                                  mem[mem_addr + 17'd1], mem[mem_addr]};
        endcase
    end

    // Memory writes, plus a one-shot preload while mem_init is high.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
            {mem[17'h1003], mem[17'h1002], mem[17'h1001], mem[17'h1000]} <= 32'h8000_00F0;
            {mem[17'h100B], mem[17'h100A], mem[17'h1009], mem[17'h1008]} <= 32'h0BAD_F00D;
            {mem[17'h100F], mem[17'h100E], mem[17'h100D], mem[17'h100C]} <= 32'h1122_3344;
        end else if (mem_we) begin
            case (mem_type)
                2'b00: {mem[mem_addr + 17'd3], mem[mem_addr + 17'd2],
                        mem[mem_addr + 17'd1], mem[mem_addr]} <= mem_wdata;
                2'b01: mem[mem_addr] <= mem_wdata[7:0];
                2'b10: {mem[mem_addr + 17'd1], mem[mem_addr]} <= mem_wdata[15:0];
                default: ;
            endcase
        end
    end

    // Monitor: count write pulses and any cycle with both acks high.
    always @(negedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (ack0 && ack1) overlap_cnt <= overlap_cnt + 1;
    end

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {mem[a + 17'd3], mem[a + 17'd2], mem[a + 17'd1], mem[a]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        req0 = 1'b0; we0 = 1'b0; type0 = 2'b00; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; type1 = 2'b00; addr1 = '0; wdata1 = '0;
    endtask

    typedef struct {
        logic          port;
        logic          we;
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[15];

    // Apply one transaction from IDLE and check the ACCESS and DONE cycles.
    task automatic run_vec(input int idx, input vec_t v);
        logic exp_we;
        int   we_before;
        exp_we = v.we && (v.typ != 2'b11);
        if (v.port) begin
            req1 = 1'b1; we1 = v.we; type1 = v.typ; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; we0 = v.we; type0 = v.typ; addr0 = v.addr; wdata0 = v.wdata;
        end
        we_before = we_cnt;
        step();
        chk($sformatf("v%0d access_state", idx), {30'd0, dbg_state}, 32'd1);
        chk($sformatf("v%0d mem_addr", idx), {15'd0, mem_addr}, {15'd0, v.addr});
        chk($sformatf("v%0d mem_type", idx), {30'd0, mem_type}, {30'd0, v.typ});
        chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        chk($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, exp_we});
        chk($sformatf("v%0d early_ack", idx), {30'd0, ack1, ack0}, 32'd0);
        step();
        if (v.port) exp_r1 = v.exp_rdata;
        else        exp_r0 = v.exp_rdata;
        chk($sformatf("v%0d acks", idx), {30'd0, ack1, ack0}, v.port ? 32'd2 : 32'd1);
        chk($sformatf("v%0d errs", idx), {30'd0, err1, err0},
            v.exp_err ? (v.port ? 32'd2 : 32'd1) : 32'd0);
        chk($sformatf("v%0d rdata0", idx), rdata0, exp_r0);
        chk($sformatf("v%0d rdata1", idx), rdata1, exp_r1);
        chk($sformatf("v%0d we_pulses", idx), we_cnt - we_before, {31'd0, exp_we});
        idle_ports();
        step();
    endtask

    initial begin
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];
        int          idx;

        //                port  we    typ    addr      wdata          exp_rdata      err
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 17'h1000, 32'h0,          32'h8000_00F0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'b00, 17'h1004, 32'hDEAD_BEEF,  32'h0,         1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 17'h1004, 32'h0,          32'hFFFF_FFEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'b10, 17'h1004, 32'h0,          32'hFFFF_BEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'b11, 17'h1008, 32'h1234_5678,  32'h0,         1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 17'h1008, 32'h0,          32'h0BAD_F00D, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 17'h1000, 32'h0,          32'hFFFF_FFF0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'b01, 17'h1001, 32'h0,          32'h0,         1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'b10, 17'h1002, 32'h0,          32'hFFFF_8000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 17'h100C, 32'hFFFF_FF7F,  32'h0,         1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 17'h100C, 32'h0,          32'h1122_337F, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'b11, 17'h1000, 32'h0,          32'h0,         1'b1};
        vecs[12] = '{1'b1, 1'b1, 2'b10, 17'h100E, 32'h0000_ABCD,  32'h0,         1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'b00, 17'h100C, 32'h0,          32'hABCD_337F, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 2'b10, 17'h1008, 32'h0,          32'hFFFF_F00D, 1'b0};

        // Reset state
        step();
        step();
        mem_init = 1'b0;
        chk("reset_outputs", {ack0, ack1, err0, err1, mem_we, mem_type, dbg_state}, 32'd0);
        chk("reset_rdata", rdata0 | rdata1, 32'd0);
        chk("reset_mem_bus", mem_wdata | {15'd0, mem_addr}, 32'd0);
        rst = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);
        chk("illegal_no_write_1008", mem_word(17'h1008), 32'h0BAD_F00D);

        // Contention from reset: both ports request continuously.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_r0 = '0;
        exp_r1 = '0;
        req0 = 1'b1; type0 = 2'b00; addr0 = 17'h1000;
        req1 = 1'b1; type1 = 2'b00; addr1 = 17'h1004;
        for (int k = 0; k < 11; k++) begin
            step();
            if (k % 3 == 1) begin
                if ((k / 3) % 2 == 0) exp_r0 = 32'h8000_00F0;
                else                  exp_r1 = 32'hDEAD_BEEF;
                chk($sformatf("cont k%0d acks", k), {30'd0, ack1, ack0},
                    ((k / 3) % 2 == 0) ? 32'd1 : 32'd2);
                chk($sformatf("cont k%0d rdata0", k), rdata0, exp_r0);
                chk($sformatf("cont k%0d rdata1", k), rdata1, exp_r1);
            end else begin
                chk($sformatf("cont k%0d acks", k), {30'd0, ack1, ack0}, 32'd0);
            end
        end
        idle_ports();
        step();

        // Reset during a write ACCESS.
        req0 = 1'b1; we0 = 1'b1; type0 = 2'b00; addr0 = 17'h1010; wdata0 = 32'hA5A5_A5A5;
        step();
        chk("rst_mid pre mem_we", {31'd0, mem_we}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid mem_we_drop", {31'd0, mem_we}, 32'd0);
        chk("rst_mid outputs", {ack0, ack1, err0, err1, mem_type, dbg_state}, 32'd0);
        chk("rst_mid rdata", rdata0 | rdata1, 32'd0);
        chk("rst_mid mem_bus", mem_wdata | {15'd0, mem_addr}, 32'd0);
        step();
        chk("rst_mid no_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_mid no_commit", mem_word(17'h1010), 32'h0);
        rst = 1'b0;
        exp_r0 = '0;
        exp_r1 = '0;
        step();
        chk("rst_retry access mem_we", {31'd0, mem_we}, 32'd1);
        step();
        chk("rst_retry ack0", {30'd0, ack1, ack0}, 32'd1);
        chk("rst_retry commit", mem_word(17'h1010), 32'hA5A5_A5A5);
        idle_ports();
        step();

        // Back-to-back reads on port 0; fields are updated in each ack cycle.
        b2b_addr = '{32'h1000, 32'h1004, 32'h1008};
        b2b_data = '{32'h8000_00F0, 32'hDEAD_BEEF, 32'h0BAD_F00D};
        idx = 0;
        req0 = 1'b1; we0 = 1'b0; type0 = 2'b00; addr0 = b2b_addr[0][AW-1:0];
        for (int k = 0; k < 8; k++) begin
            step();
            if (k % 3 == 1) begin
                chk($sformatf("b2b k%0d ack0", k), {30'd0, ack1, ack0}, 32'd1);
                chk($sformatf("b2b k%0d rdata0", k), rdata0, b2b_data[idx]);
                idx++;
                if (idx < 3) addr0 = b2b_addr[idx][AW-1:0];
                else         req0 = 1'b0;
            end else begin
                chk($sformatf("b2b k%0d ack0", k), {30'd0, ack1, ack0}, 32'd0);
            end
        end
        idle_ports();
        step();

        chk("never_both_acks", overlap_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
